// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI mode-0 master controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV system clocks while enabled.
// rise_tick/fall_tick are high in the cycle whose closing edge changes sclk,
// so the controller can act on the same edge that moves sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = spi_pkg::DEF_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  // Divider counts 0..CLK_DIV-1 and flips sclk on wrap; cleared whenever disabled.
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one full-duplex DATA_WIDTH-bit transfer per accepted start.
//
// state | meaning
// IDLE  | cs_n high, mosi 0, waiting for start
// SETUP | cs_n low, first bit on mosi, sclk low for CLK_DIV cycles
// SHIFT | sclk running; sample miso on rise, advance mosi on fall
// HOLD  | cs_n still low, sclk low for CLK_DIV cycles after last fall
// DONE  | cs_n high, done pulse, rx_data updated; back to IDLE next cycle
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  state_t                state;
  // MSB goes straight to mosi at accept, so only the remaining bits are stored.
  logic [DATA_WIDTH-2:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [BIT_W-1:0]      bit_cnt;
  // SETUP/HOLD dwell timer: loaded with CLK_DIV-1, terminal count at zero.
  logic [DIV_W-1:0]      wait_cnt;
  logic                  rise_tick;
  logic                  fall_tick;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clock    (clock),
    .reset    (reset),
    .en       (state == SHIFT),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // Transfer sequencing, shift registers and all registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mosi <= 1'b0;
          if (start) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            tx_sh    <= tx_data[DATA_WIDTH-2:0];
            mosi     <= tx_data[DATA_WIDTH-1];
            rx_sh    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= DIV_W'(CLK_DIV - 1);
          end
        end
        SETUP: begin
          if (wait_cnt == '0) begin
            state <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
          end
          if (fall_tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              state    <= HOLD;
              wait_cnt <= DIV_W'(CLK_DIV - 1);
            end else begin
              mosi  <= tx_sh[DATA_WIDTH-2];
              tx_sh <= tx_sh << 1;
            end
          end
        end
        HOLD: begin
          if (wait_cnt == '0) begin
            state   <= DONE;
            done    <= 1'b1;
            cs_n    <= 1'b1;
            rx_data <= rx_sh;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          mosi  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl at default sizing (8 bits, CLK_DIV 4).
module tb_spi_master_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       mosi;
  wire        miso;
  logic       cs_n;

  logic       loop_en;
  logic       miso_fixed;

  int checks = 0;
  int errors = 0;

  int         sclk_rises;
  int         done_cnt;
  int         cs_low_cnt;
  logic [7:0] mosi_bits;
  logic       mosi_one;

  assign miso = loop_en ? mosi : miso_fixed;

  spi_master_ctrl #(
    .DATA_WIDTH(8),
    .CLK_DIV   (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .tx_data(tx_data),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .cs_n   (cs_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge sclk) begin
    sclk_rises = sclk_rises + 1;
    mosi_bits  = {mosi_bits[6:0], mosi};
  end

  always @(posedge clock) begin
    if (done) done_cnt = done_cnt + 1;
    if (!cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (mosi) mosi_one = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    sclk_rises = 0;
    done_cnt   = 0;
    cs_low_cnt = 0;
    mosi_bits  = 8'h00;
    mosi_one   = 1'b0;
  endtask

  // Accept a transfer on the next edge, then clear the monitors.
  task automatic accept(input logic [7:0] word);
    tx_data = word;
    start   = 1'b1;
    tick();
    clear_mon();
    start   = 1'b0;
    tx_data = 8'h00;
  endtask

  task automatic run_until_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [12:0] idle_vec();
    return {cs_n, sclk, mosi, busy, done, rx_data};
  endfunction

  int cyc;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    tx_data    = 8'h00;
    loop_en    = 1'b1;
    miso_fixed = 1'b0;
    clear_mon();

    // 1: reset and quiet idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", 32'(idle_vec()), 32'h1000);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", 32'(idle_vec()), 32'h1000);
    end

    // 2: loopback A5
    accept(8'hA5);
    check("t2_cs_low_on_accept", 32'(cs_n), 32'd0);
    check("t2_busy_on_accept", 32'(busy), 32'd1);
    run_until_done(cyc);
    check("t2_done_latency", 32'(cyc), 32'd72);
    check("t2_rx_data", 32'(rx_data), 32'hA5);
    check("t2_cs_low_cycles", 32'(cs_low_cnt), 32'd72);
    check("t2_sclk_rises", 32'(sclk_rises), 32'd8);
    check("t2_mosi_bits", 32'(mosi_bits), 32'hA5);
    check("t2_cs_high_at_done", 32'(cs_n), 32'd1);
    tick();
    check("t2_busy_after_done", 32'(busy), 32'd0);
    check("t2_done_one_cycle", 32'(done), 32'd0);
    check("t2_done_count", 32'(done_cnt), 32'd1);
    check("t2_mosi_idle", 32'(mosi), 32'd0);

    // 3: miso tied high, tx 00
    loop_en    = 1'b0;
    miso_fixed = 1'b1;
    accept(8'h00);
    run_until_done(cyc);
    check("t3_done_latency", 32'(cyc), 32'd72);
    check("t3_rx_data", 32'(rx_data), 32'hFF);
    check("t3_mosi_never_high", 32'(mosi_one), 32'd0);
    check("t3_sclk_rises", 32'(sclk_rises), 32'd8);
    tick();

    // 4: start while busy is ignored
    loop_en = 1'b1;
    accept(8'h5A);
    repeat (9) tick();
    start   = 1'b1;
    tx_data = 8'h3C;
    tick();
    start   = 1'b0;
    tx_data = 8'h00;
    run_until_done(cyc);
    check("t4_done_latency", 32'(cyc + 10), 32'd72);
    check("t4_rx_data", 32'(rx_data), 32'h5A);
    repeat (80) tick();
    check("t4_single_done", 32'(done_cnt), 32'd1);
    check("t4_idle_after", 32'(busy), 32'd0);
    check("t4_sclk_rises", 32'(sclk_rises), 32'd8);

    // 5: reset mid-transfer aborts without done
    accept(8'hFF);
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_abort_outputs", 32'(idle_vec()), 32'h1000);
    repeat (80) tick();
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_quiet_after", 32'(idle_vec()), 32'h1000);
    accept(8'hC3);
    run_until_done(cyc);
    check("t5_done_latency", 32'(cyc), 32'd72);
    check("t5_rx_data", 32'(rx_data), 32'hC3);
    tick();

    // 6: start held high, back-to-back transfers
    tx_data = 8'h96;
    start   = 1'b1;
    tick();
    clear_mon();
    tx_data = 8'h69;
    run_until_done(cyc);
    check("t6_first_latency", 32'(cyc), 32'd72);
    check("t6_first_rx", 32'(rx_data), 32'h96);
    check("t6_cs_high_done", 32'(cs_n), 32'd1);
    tick();
    check("t6_cs_high_gap", 32'(cs_n), 32'd1);
    check("t6_idle_gap", 32'(busy), 32'd0);
    tick();
    check("t6_cs_low_again", 32'(cs_n), 32'd0);
    tx_data = 8'h00;
    run_until_done(cyc);
    start = 1'b0;
    check("t6_done_spacing", 32'(cyc + 2), 32'd74);
    check("t6_second_rx", 32'(rx_data), 32'h69);
    tick();
    tick();
    check("t6_done_count", 32'(done_cnt), 32'd2);
    check("t6_idle_end", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
